// File: rtl/fpaddsub_share_ctrl_pkg.sv
// Shared definitions for the FP add/sub sharing controller.
// Flag bit positions and op encodings match the FP add/sub datapath.
package fpaddsub_share_ctrl_pkg;

   localparam int DWIDTH = 16;
   localparam int FLAGW  = 5;

   localparam int FLAG_OVF = 4;
   localparam int FLAG_UNF = 3;
   localparam int FLAG_DBZ = 2;
   localparam int FLAG_INV = 1;
   localparam int FLAG_INX = 0;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } fp_op_e;

endpackage

// File: rtl/fpaddsub_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches valid from ptr upward,
// wrapping to 0, and grants the first set bit.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int TW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [TW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [TW-1:0] gidx,
   output logic          gnt_any
);

   // first valid requester at or after ptr wins
   always_comb begin
      int j;
      j       = 0;
      grant   = '0;
      gidx    = '0;
      gnt_any = 1'b0;
      for (int o = 0; o < N; o++) begin
         j = int'(ptr) + o;
         if (j >= N) j = j - N;
         if (!gnt_any && valid[j]) begin
            grant[j] = 1'b1;
            gidx     = TW'(j);
            gnt_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpaddsub_share_ctrl.sv
// Shares one pipelined FP add/sub unit among NREQ requesters,
// tracking owners down a tag pipe and keeping sticky flags.
module fpaddsub_share_ctrl
   import fpaddsub_share_ctrl_pkg::*;
#(
   parameter  int NREQ = 4,
   parameter  int LAT  = 4,
   parameter  int DW   = DWIDTH,
   localparam int TAGW = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*DW-1:0]    req_a,
   input  logic [NREQ*DW-1:0]    req_b,
   input  logic [NREQ-1:0]       req_op,
   output logic                  fp_valid,
   output logic [DW-1:0]         fp_a,
   output logic [DW-1:0]         fp_b,
   output logic                  fp_op,
   input  logic [DW-1:0]         fp_result,
   input  logic [FLAGW-1:0]      fp_flags,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [DW-1:0]         rsp_data,
   output logic [FLAGW-1:0]      rsp_flags,
   output logic [NREQ*FLAGW-1:0] sticky_flags,
   input  logic [NREQ-1:0]       flag_clr,
   output logic [TAGW+1:0]       in_flight
);

   typedef struct packed {
      logic            v;
      logic [TAGW-1:0] t;
   } tstage_t;

   logic [TAGW-1:0] ptr;
   logic [TAGW-1:0] gidx;
   logic [NREQ-1:0] gnt;
   logic            gnt_any;
   logic [TAGW-1:0] fp_tag;
   tstage_t         tp [1:LAT];
   logic            ret;
   logic [TAGW-1:0] rtag;
   logic            rsp_any;

   rr_arbiter #(
      .N  (NREQ),
      .TW (TAGW)
   ) u_arb (
      .valid   (req_valid),
      .ptr     (ptr),
      .grant   (gnt),
      .gidx    (gidx),
      .gnt_any (gnt_any)
   );

   assign req_ready = gnt;
   assign ret       = tp[LAT].v;
   assign rtag      = tp[LAT].t;
   assign rsp_any   = |rsp_valid;

   // issue registers and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= '0;
         fp_valid <= 1'b0;
         fp_a     <= '0;
         fp_b     <= '0;
         fp_op    <= OP_ADD;
         fp_tag   <= '0;
      end else begin
         fp_valid <= gnt_any;
         if (gnt_any) begin
            fp_a   <= req_a[int'(gidx)*DW +: DW];
            fp_b   <= req_b[int'(gidx)*DW +: DW];
            fp_op  <= req_op[gidx];
            fp_tag <= gidx;
            ptr    <= (gidx == TAGW'(NREQ-1)) ? '0 : gidx + 1'b1;
         end
      end
   end

   // owner tag shadows the unit pipeline, aligned with fp_result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 1; k <= LAT; k++) tp[k] <= '0;
      end else begin
         tp[1] <= '{v: fp_valid, t: fp_tag};
         for (int k = 2; k <= LAT; k++) tp[k] <= tp[k-1];
      end
   end

   // route returning result to its owner
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_flags <= '0;
      end else begin
         rsp_valid <= ret ? (NREQ'(1) << rtag) : '0;
         if (ret) begin
            rsp_data  <= fp_result;
            rsp_flags <= fp_flags;
         end
      end
   end

   // sticky flags: clear drops old bits, a coincident return keeps new bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_flags <= '0;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            if (ret && rtag == TAGW'(k))
               sticky_flags[k*FLAGW +: FLAGW] <=
                  (flag_clr[k] ? '0 : sticky_flags[k*FLAGW +: FLAGW])
                  | fp_flags;
            else if (flag_clr[k])
               sticky_flags[k*FLAGW +: FLAGW] <= '0;
         end
      end
   end

   // ops granted but not yet delivered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_flight <= '0;
      end else begin
         unique case ({gnt_any, rsp_any})
            2'b10:   in_flight <= in_flight + 1'b1;
            2'b01:   in_flight <= in_flight - 1'b1;
            default: in_flight <= in_flight;
         endcase
      end
   end

endmodule

// File: tb/tb_fpaddsub_share_ctrl.sv
// Directed bench for fpaddsub_share_ctrl with a stand-in FP unit
// and a response scoreboard.
module tb_fpaddsub_share_ctrl;
   import fpaddsub_share_ctrl_pkg::*;

   localparam int NREQ = 4;
   localparam int LAT  = 4;
   localparam int DW   = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*DW-1:0] req_a;
   logic [NREQ*DW-1:0] req_b;
   logic [NREQ-1:0]   req_op;
   logic              fp_valid;
   logic [DW-1:0]     fp_a;
   logic [DW-1:0]     fp_b;
   logic              fp_op;
   logic [DW-1:0]     fp_result;
   logic [4:0]        fp_flags;
   logic [NREQ-1:0]   rsp_valid;
   logic [DW-1:0]     rsp_data;
   logic [4:0]        rsp_flags;
   logic [NREQ*5-1:0] sticky_flags;
   logic [NREQ-1:0]   flag_clr;
   logic [3:0]        in_flight;

   int cyc    = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      int          r;
      logic [15:0] d;
      logic [4:0]  f;
      int          c;
   } exp_t;

   exp_t q[$];
   exp_t me;

   logic [15:0] ures [LAT];
   logic [4:0]  ufl  [LAT];

   fpaddsub_share_ctrl #(
      .NREQ (NREQ),
      .LAT  (LAT),
      .DW   (DW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_op       (req_op),
      .fp_valid     (fp_valid),
      .fp_a         (fp_a),
      .fp_b         (fp_b),
      .fp_op        (fp_op),
      .fp_result    (fp_result),
      .fp_flags     (fp_flags),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_flags    (rsp_flags),
      .sticky_flags (sticky_flags),
      .flag_clr     (flag_clr),
      .in_flight    (in_flight)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // stand-in unit: 1.0+2.0 gives 0x4200, else integer add/sub;
   // flags come from the low 5 bits of operand b
   function automatic logic [15:0] fnres(logic [15:0] a, logic [15:0] b,
                                         logic op);
      if (a == 16'h3C00 && b == 16'h4000 && op == 1'b0) return 16'h4200;
      return op ? a - b : a + b;
   endfunction

   // unit pipeline, LAT cycles from fp_valid to fp_result
   always @(posedge clk) begin
      ures[0] <= fnres(fp_a, fp_b, fp_op);
      ufl[0]  <= fp_b[4:0];
      for (int k = 1; k < LAT; k++) begin
         ures[k] <= ures[k-1];
         ufl[k]  <= ufl[k-1];
      end
   end

   assign fp_result = ures[LAT-1];
   assign fp_flags  = ufl[LAT-1];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic setop(input int r, input logic [15:0] a,
                        input logic [15:0] b, input logic op);
      req_a[r*DW +: DW] = a;
      req_b[r*DW +: DW] = b;
      req_op[r]         = op;
   endtask

   task automatic push(input int r, input logic [15:0] a,
                       input logic [15:0] b, input logic op);
      exp_t e;
      e.r = r;
      e.d = fnres(a, b, op);
      e.f = b[4:0];
      e.c = cyc;
      q.push_back(e);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() != 0; i++) step();
      step();
      chk("drain_empty", q.size(), 0);
   endtask

   // scoreboard: every response must match the oldest expected one
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rsp_valid !== '0) begin
         if (q.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 0);
         end else begin
            me = q.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(1) << me.r);
            chk("rsp_data", 32'(rsp_data), 32'(me.d));
            chk("rsp_flags", 32'(rsp_flags), 32'(me.f));
            chk("rsp_latency", cyc - me.c, LAT + 2);
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      flag_clr  = '0;
      repeat (2) step();
      chk("rst_fp_valid", 32'(fp_valid), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_in_flight", 32'(in_flight), 0);
      chk("rst_sticky", 32'(sticky_flags), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      rst_n = 1'b1;
      step();

      // reset while three ops are in flight
      for (int r = 0; r < 3; r++) setop(r, 16'h1000 + 16'(r), 16'h0100, 1'b0);
      req_valid = 4'b0111;
      #1 chk("t1_g0", 32'(req_ready), 32'h1);
      step();
      #1 chk("t1_g1", 32'(req_ready), 32'h2);
      step();
      #1 chk("t1_g2", 32'(req_ready), 32'h4);
      step();
      req_valid = '0;
      chk("t1_in_flight", 32'(in_flight), 3);
      rst_n = 1'b0;
      #1;
      chk("t1_fp_valid", 32'(fp_valid), 0);
      chk("t1_fp_a", 32'(fp_a), 0);
      chk("t1_fp_b", 32'(fp_b), 0);
      chk("t1_fp_op", 32'(fp_op), 0);
      chk("t1_in_flight_rst", 32'(in_flight), 0);
      chk("t1_rsp_valid", 32'(rsp_valid), 0);
      chk("t1_rsp_data", 32'(rsp_data), 0);
      chk("t1_rsp_flags", 32'(rsp_flags), 0);
      chk("t1_sticky", 32'(sticky_flags), 0);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (10) step();
      chk("t1_post_in_flight", 32'(in_flight), 0);

      // pointer wrap with req_valid=1010
      setop(1, 16'h2000, 16'h0100, 1'b0);
      req_valid = 4'b0010;
      #1 chk("t3_pre", 32'(req_ready), 32'h2);
      push(1, 16'h2000, 16'h0100, 1'b0);
      step();
      setop(3, 16'h3000, 16'h0104, 1'b1);
      setop(1, 16'h2100, 16'h0200, 1'b0);
      req_valid = 4'b1010;
      #1 chk("t3_g3", 32'(req_ready), 32'h8);
      push(3, 16'h3000, 16'h0104, 1'b1);
      step();
      #1 chk("t3_g1", 32'(req_ready), 32'h2);
      push(1, 16'h2100, 16'h0200, 1'b0);
      step();
      req_valid = '0;
      drain();

      // 1.0 + 2.0 from requester 2
      setop(2, 16'h3C00, 16'h4000, 1'b0);
      req_valid = 4'b0100;
      #1 chk("t4_grant", 32'(req_ready), 32'h4);
      push(2, 16'h3C00, 16'h4000, 1'b0);
      step();
      req_valid = '0;
      drain();
      chk("t4_rsp_data", 32'(rsp_data), 32'h4200);
      chk("t4_in_flight", 32'(in_flight), 0);

      // sticky accumulation on requester 1
      setop(1, 16'h1111, 16'h0011, 1'b0);
      req_valid = 4'b0010;
      #1 chk("t5_g_a", 32'(req_ready), 32'h2);
      push(1, 16'h1111, 16'h0011, 1'b0);
      step();
      req_valid = '0;
      drain();
      chk("t5_sticky_a", 32'(sticky_flags[9:5]), 32'h11);
      setop(1, 16'h1234, 16'h0002, 1'b0);
      req_valid = 4'b0010;
      #1 chk("t5_g_b", 32'(req_ready), 32'h2);
      push(1, 16'h1234, 16'h0002, 1'b0);
      step();
      req_valid = '0;
      drain();
      chk("t5_sticky_b", 32'(sticky_flags[9:5]), 32'h13);

      // clear coinciding with a return to requester 1
      setop(1, 16'h0AAA, 16'h0001, 1'b0);
      req_valid = 4'b0010;
      #1 chk("t6_grant", 32'(req_ready), 32'h2);
      push(1, 16'h0AAA, 16'h0001, 1'b0);
      step();
      req_valid = '0;
      repeat (4) step();
      flag_clr = 4'b0010;
      step();
      flag_clr = '0;
      drain();
      chk("t6_sticky", 32'(sticky_flags), {12'h0, 5'b00100, 5'b0, 5'b00001, 5'b0});

      // bring pointer back to 0, then all requesters continuously
      setop(3, 16'h0500, 16'h0040, 1'b0);
      req_valid = 4'b1000;
      #1 chk("t2_pre", 32'(req_ready), 32'h8);
      push(3, 16'h0500, 16'h0040, 1'b0);
      step();
      req_valid = '0;
      drain();
      for (int r = 0; r < NREQ; r++)
         setop(r, 16'h0100 * 16'(r + 1), 16'h0020, 1'b0);
      req_valid = 4'b1111;
      for (int k = 0; k < 12; k++) begin
         #1 chk("t2_grant", 32'(req_ready), 32'(1) << (k % 4));
         chk("t2_in_flight", 32'(in_flight), (k < 6) ? k : 6);
         push(k % 4, 16'h0100 * 16'((k % 4) + 1), 16'h0020, 1'b0);
         step();
      end
      req_valid = '0;
      drain();
      chk("t2_in_flight_end", 32'(in_flight), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
